// File: rtl/fifo_event_monitor_pkg.sv
// Shared definitions for the FIFO event monitor: event-type encoding,
// default widths and a small sizing helper.
package fifo_event_monitor_pkg;

    // Event-type encoding reported in the first-error record.
    typedef enum logic {
        EVT_OVF = 1'b0,
        EVT_UDF = 1'b1
    } evt_type_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W   = 2;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_TS_W   = 32;

    // Number of readback slots addressable by a channel index of ch_w bits.
    // Slots past NUM_CH are tied to zero so an out-of-range select reads 0.
    function automatic int rb_depth(input int ch_w);
        return 1 << ch_w;
    endfunction

endpackage

// File: rtl/fifo_event_monitor_if.sv
// Bundle of FIFO status/strobe inputs, host controls and monitor results.
// master = the datapath/host side driving the monitor, slave = the monitor.
// The monitor has no handshake: every input is sampled on each rising clock
// edge and every result is valid whenever it is read.
interface fifo_event_monitor_if
    import fifo_event_monitor_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int TS_W   = DEF_TS_W
);
    logic [NUM_CH-1:0] wr_full;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] rd_empty;
    logic [NUM_CH-1:0] rd_en;
    logic              clear;
    logic [NUM_CH-1:0] clear_mask;
    logic [CH_W-1:0]   sel;

    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] underflow;
    logic              any_error;
    logic [CNT_W-1:0]  ovf_count;
    logic [CNT_W-1:0]  udf_count;
    logic              first_valid;
    logic [CH_W-1:0]   first_ch;
    logic              first_type;
    logic [TS_W-1:0]   first_time;

    modport master (
        output wr_full, wr_en, rd_empty, rd_en, clear, clear_mask, sel,
        input  overflow, underflow, any_error, ovf_count, udf_count,
               first_valid, first_ch, first_type, first_time
    );

    modport slave (
        input  wr_full, wr_en, rd_empty, rd_en, clear, clear_mask, sel,
        output overflow, underflow, any_error, ovf_count, udf_count,
               first_valid, first_ch, first_type, first_time
    );

endinterface

// File: rtl/fifo_event_monitor_sat_counter.sv
// Saturating event counter: clears on clr, counts on inc, holds at all-ones.
module sat_counter
    import fifo_event_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Clear beats increment; the count sticks at its maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_event_monitor.sv
// Multi-channel FIFO health monitor: sticky overflow/underflow flags,
// saturating per-channel event counters with selectable readback, and a
// first-error record (channel, type, timestamp) for sample-loss attribution.
module fifo_event_monitor
    import fifo_event_monitor_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int TS_W   = DEF_TS_W,
    parameter bit STRICT = 1'b1
) (
    input logic                clk,
    input logic                reset,
    fifo_event_monitor_if.slave bus
);

    localparam int RB_N = rb_depth(CH_W);

    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] udf_evt;
    logic [NUM_CH-1:0] ch_clr;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] udf_q;

    logic [CNT_W-1:0]  ovf_cnt [RB_N];
    logic [CNT_W-1:0]  udf_cnt [RB_N];
    logic [CH_W-1:0]   sel_q;
    logic [TS_W-1:0]   ts_q;

    logic              cap_hit;
    logic [CH_W-1:0]   cap_ch;
    evt_type_e         cap_type;

    logic              first_valid_q;
    logic [CH_W-1:0]   first_ch_q;
    evt_type_e         first_type_q;
    logic [TS_W-1:0]   first_time_q;

    // Strict mode counts access attempts on a full/empty FIFO; legacy mode
    // treats the full/empty level itself as the event.
    if (STRICT) begin : g_strict
        assign ovf_evt = bus.wr_full & bus.wr_en;
        assign udf_evt = bus.rd_empty & bus.rd_en;
    end else begin : g_level
        assign ovf_evt = bus.wr_full;
        assign udf_evt = bus.rd_empty;
    end

    // A global clear and a per-channel mask both wipe that channel's state.
    assign ch_clr = {NUM_CH{bus.clear}} | bus.clear_mask;

    // Sticky flags; a clear in the same cycle as an event drops the event.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= (ovf_q | ovf_evt) & ~ch_clr;
            udf_q <= (udf_q | udf_evt) & ~ch_clr;
        end
    end

    // One overflow and one underflow counter per channel; spare readback
    // slots beyond NUM_CH read as zero.
    for (genvar g = 0; g < RB_N; g++) begin : g_ch
        if (g < NUM_CH) begin : g_live
            sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (ch_clr[g]),
                .inc   (ovf_evt[g]),
                .cnt   (ovf_cnt[g])
            );
            sat_counter #(.WIDTH(CNT_W)) u_udf_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (ch_clr[g]),
                .inc   (udf_evt[g]),
                .cnt   (udf_cnt[g])
            );
        end else begin : g_pad
            assign ovf_cnt[g] = '0;
            assign udf_cnt[g] = '0;
        end
    end

    // Free-running timestamp; only reset touches it, clear does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Priority encoder: lowest channel wins, overflow beats underflow within
    // a channel. Scanning downwards lets the lowest hit overwrite the rest.
    always_comb begin
        cap_hit  = 1'b0;
        cap_ch   = '0;
        cap_type = EVT_OVF;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ovf_evt[i] || udf_evt[i]) begin
                cap_hit  = 1'b1;
                cap_ch   = CH_W'(i);
                cap_type = ovf_evt[i] ? EVT_OVF : EVT_UDF;
            end
        end
    end

    // First-error record: latched once, held until a global clear.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            first_type_q  <= EVT_OVF;
            first_time_q  <= '0;
        end else if (!first_valid_q && cap_hit) begin
            first_valid_q <= 1'b1;
            first_ch_q    <= cap_ch;
            first_type_q  <= cap_type;
            first_time_q  <= ts_q;
        end
    end

    // Register the readback select; the counters themselves are already
    // registered, so the mux below returns their state at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
        end else begin
            sel_q <= bus.sel;
        end
    end

    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
    assign bus.any_error   = |{ovf_q, udf_q};
    assign bus.ovf_count   = ovf_cnt[sel_q];
    assign bus.udf_count   = udf_cnt[sel_q];
    assign bus.first_valid = first_valid_q;
    assign bus.first_ch    = first_ch_q;
    assign bus.first_type  = first_type_q;
    assign bus.first_time  = first_time_q;

endmodule

// File: tb/tb_fifo_event_monitor.sv
// Bench for fifo_event_monitor: instance A (STRICT=1, CNT_W=4, CH_W=2) runs a
// stimulus table; instance B (STRICT=0, CNT_W=16, CH_W=3) runs a hand-written
// sequence covering legacy level events and out-of-range select.
module tb_fifo_event_monitor;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    fifo_event_monitor_if #(.NUM_CH(4), .CH_W(2), .CNT_W(4),  .TS_W(32)) ifa ();
    fifo_event_monitor_if #(.NUM_CH(4), .CH_W(3), .CNT_W(16), .TS_W(32)) ifb ();

    fifo_event_monitor #(
        .NUM_CH(4), .CH_W(2), .CNT_W(4), .TS_W(32), .STRICT(1'b1)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa.slave)
    );

    fifo_event_monitor #(
        .NUM_CH(4), .CH_W(3), .CNT_W(16), .TS_W(32), .STRICT(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [3:0]  ovf;
        logic [3:0]  udf;
        logic        any;
        logic [15:0] ocnt;
        logic [15:0] ucnt;
        logic        fv;
        logic [2:0]  fch;
        logic        ftype;
        logic [31:0] ftime;
    } snap_t;

    localparam int SW = $bits(snap_t);

    typedef struct {
        string      name;
        bit         chk;
        bit         b;
        logic       rst;
        logic       clr;
        logic [3:0] cm;
        logic [3:0] wf;
        logic [3:0] we;
        logic [3:0] re;
        logic [3:0] rn;
        logic [2:0] sel;
        snap_t      exp;
    } vec_t;

    vec_t            vecs[$];
    logic [SW-1:0]   exp_q[$];
    int              checks   = 0;
    int              failures = 0;

    function automatic snap_t mk(input logic [3:0] ovf, input logic [3:0] udf,
                                 input logic [15:0] ocnt, input logic [15:0] ucnt,
                                 input logic fv, input logic [2:0] fch,
                                 input logic ftype, input logic [31:0] ftime);
        snap_t s;
        s.ovf   = ovf;
        s.udf   = udf;
        s.any   = (|ovf) | (|udf);
        s.ocnt  = ocnt;
        s.ucnt  = ucnt;
        s.fv    = fv;
        s.fch   = fch;
        s.ftype = ftype;
        s.ftime = ftime;
        return s;
    endfunction

    function automatic vec_t mkv(input string name, input bit chk, input bit b,
                                 input logic rst, input logic clr, input logic [3:0] cm,
                                 input logic [3:0] wf, input logic [3:0] we,
                                 input logic [3:0] re, input logic [3:0] rn,
                                 input logic [2:0] sel, input snap_t exp);
        vec_t v;
        v.name = name; v.chk = chk; v.b = b; v.rst = rst; v.clr = clr; v.cm = cm;
        v.wf = wf; v.we = we; v.re = re; v.rn = rn; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    function automatic snap_t sample(input bit b);
        snap_t s;
        if (!b) begin
            s = {ifa.overflow, ifa.underflow, ifa.any_error, 12'b0, ifa.ovf_count,
                 12'b0, ifa.udf_count, ifa.first_valid, 1'b0, ifa.first_ch,
                 ifa.first_type, ifa.first_time};
        end else begin
            s = {ifb.overflow, ifb.underflow, ifb.any_error, ifb.ovf_count,
                 ifb.udf_count, ifb.first_valid, ifb.first_ch,
                 ifb.first_type, ifb.first_time};
        end
        return s;
    endfunction

    task automatic drive(input vec_t v);
        if (!v.b) begin
            reset_a = v.rst;
            ifa.clear = v.clr; ifa.clear_mask = v.cm;
            ifa.wr_full = v.wf; ifa.wr_en = v.we;
            ifa.rd_empty = v.re; ifa.rd_en = v.rn;
            ifa.sel = v.sel[1:0];
        end else begin
            reset_a = 1'b0;
            ifa.clear = 1'b0; ifa.clear_mask = '0;
            ifa.wr_full = '0; ifa.wr_en = '0; ifa.rd_empty = '0; ifa.rd_en = '0;
            ifa.sel = '0;
            reset_b = v.rst;
            ifb.clear = v.clr; ifb.clear_mask = v.cm;
            ifb.wr_full = v.wf; ifb.wr_en = v.we;
            ifb.rd_empty = v.re; ifb.rd_en = v.rn;
            ifb.sel = v.sel;
        end
    endtask

    task automatic compare(input string name, input bit b);
        snap_t act;
        snap_t exp;
        exp = exp_q.pop_front();
        act = sample(b);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got ovf=%h udf=%h any=%0d ocnt=%0d ucnt=%0d fv=%0d fch=%0d ftype=%0d ftime=%0d | want ovf=%h udf=%h any=%0d ocnt=%0d ucnt=%0d fv=%0d fch=%0d ftype=%0d ftime=%0d",
                     name, $time, act.ovf, act.udf, act.any, act.ocnt, act.ucnt, act.fv,
                     act.fch, act.ftype, act.ftime, exp.ovf, exp.udf, exp.any, exp.ocnt,
                     exp.ucnt, exp.fv, exp.fch, exp.ftype, exp.ftime);
        end
    endtask

    // Drive on the falling edge, let the rising edge consume it, check on the
    // following falling edge.
    task automatic apply(input vec_t v);
        drive(v);
        if (v.chk) exp_q.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        if (v.chk) compare(v.name, v.b);
    endtask

    initial begin
        snap_t z;
        z = mk(4'h0, 4'h0, 16'd0, 16'd0, 1'b0, 3'd0, 1'b0, 32'd0);

        reset_a = 1'b1;
        reset_b = 1'b1;
        ifa.clear = 1'b0; ifa.clear_mask = '0; ifa.wr_full = '0; ifa.wr_en = '0;
        ifa.rd_empty = '0; ifa.rd_en = '0; ifa.sel = '0;
        ifb.clear = 1'b0; ifb.clear_mask = '0; ifb.wr_full = '0; ifb.wr_en = '0;
        ifb.rd_empty = '0; ifb.rd_en = '0; ifb.sel = '0;

        // ---- Table for instance A; the timestamp of each row is noted ----
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv("a_reset", 1, 0, 1, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 3'd0, z));
        for (int i = 0; i < 10; i++)   // ts 0..9
            vecs.push_back(mkv("a_idle_full_empty", 1, 0, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 3'd0, z));
        // ts 10: strobes without full/empty are not events in strict mode
        vecs.push_back(mkv("a_strobe_no_full", 1, 0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 3'd0, z));
        for (int i = 0; i < 89; i++)   // ts 11..99, random sel, no events
            vecs.push_back(mkv("a_pad", 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                               3'($urandom_range(0, 3)), z));
        for (int k = 0; k < 5; k++)    // ts 100..104
            vecs.push_back(mkv("a_ch2_ovf", 1, 0, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 3'd2,
                               mk(4'h4, 4'h0, 16'(k + 1), 16'd0, 1'b1, 3'd2, 1'b0, 32'd100)));
        vecs.push_back(mkv("a_ch2_full_no_en", 1, 0, 0, 0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2,
                           mk(4'h4, 4'h0, 16'd5, 16'd0, 1'b1, 3'd2, 1'b0, 32'd100)));    // ts 105
        vecs.push_back(mkv("a_clear", 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd2, z)); // ts 106
        vecs.push_back(mkv("a_ch3ovf_ch1udf", 1, 0, 0, 0, 4'h0, 4'h8, 4'h8, 4'h2, 4'h2, 3'd1,
                           mk(4'h8, 4'h2, 16'd0, 16'd1, 1'b1, 3'd1, 1'b1, 32'd107)));   // ts 107
        vecs.push_back(mkv("a_sel3", 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd3,
                           mk(4'h8, 4'h2, 16'd1, 16'd0, 1'b1, 3'd1, 1'b1, 32'd107)));   // ts 108
        vecs.push_back(mkv("a_clear2", 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, z)); // ts 109
        for (int k = 0; k < 20; k++)   // ts 110..129
            vecs.push_back(mkv("a_ch0_udf_sat", 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 3'd0,
                               mk(4'h0, 4'h1, 16'd0, 16'((k + 1 > 15) ? 15 : k + 1),
                                  1'b1, 3'd0, 1'b1, 32'd110)));
        vecs.push_back(mkv("a_clear_mask0", 1, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0,
                           mk(4'h0, 4'h0, 16'd0, 16'd0, 1'b1, 3'd0, 1'b1, 32'd110)));   // ts 130
        vecs.push_back(mkv("a_mask_drops_evt", 1, 0, 0, 0, 4'h1, 4'h2, 4'h2, 4'h1, 4'h1, 3'd1,
                           mk(4'h2, 4'h0, 16'd1, 16'd0, 1'b1, 3'd0, 1'b1, 32'd110)));   // ts 131
        vecs.push_back(mkv("a_clear_with_evt", 1, 0, 0, 1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd0, z)); // ts 132
        vecs.push_back(mkv("a_evt_after_clear", 1, 0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd0,
                           mk(4'h1, 4'h0, 16'd1, 16'd0, 1'b1, 3'd0, 1'b0, 32'd133)));   // ts 133

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // ---- Hand-written: reset mid-stream on A, then a same-channel tie ----
        apply(mkv("a_reset_midstream", 1, 0, 1, 0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 3'd2, z));
        apply(mkv("a_ovf_udf_same_ch", 1, 0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h5, 3'd0,
                  mk(4'h1, 4'h5, 16'd1, 16'd1, 1'b1, 3'd0, 1'b0, 32'd0)));
        apply(mkv("a_sel2_after_tie", 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd2,
                  mk(4'h1, 4'h5, 16'd0, 16'd1, 1'b1, 3'd0, 1'b0, 32'd0)));

        // ---- Hand-written: instance B, legacy level events ----
        apply(mkv("b_reset", 1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, z));
        for (int k = 0; k < 3; k++)
            apply(mkv("b_ch3_empty_level", 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 3'd3,
                      mk(4'h0, 4'h8, 16'd0, 16'(k + 1), 1'b1, 3'd3, 1'b1, 32'd0)));
        apply(mkv("b_sel_out_of_range", 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd5,
                  mk(4'h0, 4'h8, 16'd0, 16'd0, 1'b1, 3'd3, 1'b1, 32'd0)));
        apply(mkv("b_sel3_again", 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd3,
                  mk(4'h0, 4'h8, 16'd0, 16'd3, 1'b1, 3'd3, 1'b1, 32'd0)));
        apply(mkv("b_ch0_full_level", 1, 1, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd0,
                  mk(4'h1, 4'h8, 16'd1, 16'd0, 1'b1, 3'd3, 1'b1, 32'd0)));

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
